// File: rtl/message_rx_msg_parse.sv
// Frame sync and UTC hour/minute/second extraction for the 120-bit time message.
// Build macro MSG_RX_RANGE_CHECK_EN enables the field range check and field_err_o.
module message_rx_msg_parse #(
  parameter int MISS_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_i,
  input  logic         data_valid_i,
  output logic [4:0]   rx_utc_time_hour,
  output logic [5:0]   rx_utc_time_minute,
  output logic [5:0]   rx_utc_time_second,
  output logic [119:0] message_o,
  output logic         msg_valid_o,
  output logic         hdr_err_o,
  output logic         field_err_o,
  output logic         locked_o
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [102:0] HDR = {39'd0, 64'h5a5a_5a5a_5a5a_5a5a};

  typedef enum logic [1:0] {HUNT, PAYLOAD, TRACK} state_t;

  state_t        state;
  // Oldest history bit is never compared, so only 102 bits are kept.
  logic [101:0]  sr;
  logic [6:0]    cnt;
  logic [MW-1:0] miss;
  logic          disc;
  logic          bad;
  logic [15:0]   pl;

  logic [16:0]   fields;
  logic          hdr_hit;
  logic          bad_n;
  logic          take;
  logic          range_ok;

  always_comb begin
    fields  = {pl, data_i};
    hdr_hit = ({sr, data_i} == HDR);
    bad_n   = bad | (data_i != HDR[7'd102 - cnt]);
    take    = data_valid_i && (state == PAYLOAD)
              && (cnt == 7'd16) && !disc;
`ifdef MSG_RX_RANGE_CHECK_EN
    range_ok = (fields[16:12] <= 5'd23)
               && (fields[11:6] <= 6'd59)
               && (fields[5:0] <= 6'd59);
`else
    range_ok = 1'b1;
`endif
  end

`ifdef MSG_RX_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) field_err_o <= 1'b0;
    else     field_err_o <= take && !range_ok;
  end
`else
  assign field_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= HUNT;
      sr                 <= '0;
      cnt                <= '0;
      miss               <= '0;
      disc               <= 1'b0;
      bad                <= 1'b0;
      pl                 <= '0;
      rx_utc_time_hour   <= '0;
      rx_utc_time_minute <= '0;
      rx_utc_time_second <= '0;
      message_o          <= '0;
      msg_valid_o        <= 1'b0;
      hdr_err_o          <= 1'b0;
      locked_o           <= 1'b0;
    end else begin
      msg_valid_o <= 1'b0;
      hdr_err_o   <= 1'b0;
      if (take && range_ok) begin
        message_o          <= {HDR, fields};
        rx_utc_time_hour   <= fields[16:12];
        rx_utc_time_minute <= fields[11:6];
        rx_utc_time_second <= fields[5:0];
        msg_valid_o        <= 1'b1;
      end
      if (data_valid_i) begin
        sr <= {sr[100:0], data_i};
        unique case (state)
          HUNT: begin
            if (hdr_hit) begin
              state    <= PAYLOAD;
              cnt      <= '0;
              disc     <= 1'b0;
              miss     <= '0;
              locked_o <= 1'b1;
            end
          end
          PAYLOAD: begin
            pl <= fields[15:0];
            if (cnt == 7'd16) begin
              state <= TRACK;
              cnt   <= '0;
              bad   <= 1'b0;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          TRACK: begin
            bad <= bad_n;
            if (cnt == 7'd102) begin
              cnt <= '0;
              if (!bad_n) begin
                state <= PAYLOAD;
                disc  <= 1'b0;
                miss  <= '0;
              end else if (int'(miss) + 1 < MISS_LIMIT) begin
                hdr_err_o <= 1'b1;
                miss      <= miss + 1'b1;
                state     <= PAYLOAD;
                disc      <= 1'b1;
              end else begin
                hdr_err_o <= 1'b1;
                miss      <= '0;
                state     <= HUNT;
                locked_o  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
